sram_scanline_fetcher: RTL and testbench

Parametrised SRAM-to-VGA pixel path: prefetches the next scanline from the 16-bit SRAM framebuffer into a ping-pong line buffer, then supplies 8-bit R/G/B for the current `drawx`/`drawy`. It sits between the VGA timing controller and the SRAM pins, replacing the fixed pixel export of the ECE385 system. It adds selectable pixel depth, page-flipped double framebuffers and an arbitrated CPU write port.

---
 rtl/sram_scanline_fetcher_pkg.sv | 30 +++
 rtl/sram_scanline_fetcher_if.sv | 32 +++
 rtl/sram_scanline_fetcher_line_buffer.sv | 23 ++
 rtl/sram_scanline_fetcher.sv | 221 ++++++++++++++++++++++
 tb/tb_sram_scanline_fetcher.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/sram_scanline_fetcher_pkg.sv
// Shared types and colour expansion helpers for the SRAM scanline fetcher.
// Default resolution constants match standard 640x480 VGA timing.
package ece385_vga_pkg;

    localparam int unsigned DEF_H_RES   = 640;
    localparam int unsigned DEF_V_RES   = 480;
    localparam int unsigned DEF_V_TOTAL = 525;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_WR1,
        ST_WR2
    } state_t;

    // Replicate the top bits of each field so that full scale maps to 8'hFF.
    function automatic logic [23:0] expand565(input logic [15:0] w);
        return {w[15:11], w[15:13],
                w[10:5],  w[10:9],
                w[4:0],   w[4:2]};
    endfunction

    function automatic logic [23:0] expand332(input logic [7:0] p);
        return {p[7:5], p[7:5], p[7:6],
                p[4:2], p[4:2], p[4:3],
                {4{p[1:0]}}};
    endfunction

endpackage

// File: rtl/sram_scanline_fetcher_if.sv
// CPU write port and SRAM pin bundle for the scanline fetcher.
// master = fetcher side, slave = CPU/SRAM side.
interface sram_scanline_fetcher_if;

    logic [19:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [1:0]  cpu_be;
    logic        cpu_req;
    logic        cpu_ack;
    logic [19:0] sram_addr;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic        sram_ub_n;
    logic        sram_lb_n;
    logic [15:0] sram_dq_o;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_i;

    modport master (
        input  cpu_addr, cpu_wdata, cpu_be, cpu_req, sram_dq_i,
        output cpu_ack, sram_addr, sram_ce_n, sram_oe_n, sram_we_n,
        output sram_ub_n, sram_lb_n, sram_dq_o, sram_dq_oe
    );

    modport slave (
        output cpu_addr, cpu_wdata, cpu_be, cpu_req, sram_dq_i,
        input  cpu_ack, sram_addr, sram_ce_n, sram_oe_n, sram_we_n,
        input  sram_ub_n, sram_lb_n, sram_dq_o, sram_dq_oe
    );

endinterface

// File: rtl/sram_scanline_fetcher_line_buffer.sv
// Ping-pong scanline storage: simple dual-port RAM with registered read.
// Contents are not reset; every displayed word is written by a fetch first.
module line_buffer #(
    parameter int unsigned DEPTH = 1280,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [15:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [15:0]   o_rdata
);

    logic [15:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/sram_scanline_fetcher.sv
// Prefetches the next scanline from SRAM into a ping-pong buffer and
// decodes the current pixel; also arbitrates a CPU write port onto SRAM.
module sram_scanline_fetcher
    import ece385_vga_pkg::*;
#(
    parameter int unsigned H_RES    = DEF_H_RES,
    parameter int unsigned V_RES    = DEF_V_RES,
    parameter int unsigned V_TOTAL  = DEF_V_TOTAL,
    parameter int unsigned BPP      = 16,
    parameter logic [19:0] FB0_BASE = 20'h00000,
    parameter logic [19:0] FB1_BASE = 20'h40000
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic [9:0] vga_drawx,
    input  logic [9:0] vga_drawy,
    input  logic       fb_sel,
    output logic       fb_active,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    sram_scanline_fetcher_if.master bus
);

    localparam int unsigned WPL   = H_RES * BPP / 16;
    localparam int unsigned DEPTH = 2 * WPL;
    localparam int unsigned AW    = $clog2(DEPTH);

    state_t      r_state;
    logic [9:0]  r_drawy_q;
    logic        r_primed;
    logic        r_pend;
    logic [9:0]  r_pend_line;
    logic [AW-1:0] r_cnt;
    logic        r_half;
    logic        r_cap_v;
    logic        r_cap_half;
    logic [AW-1:0] r_cap_idx;
    logic        r_fb_active;
    logic [19:0] r_addr;
    logic        r_ce_n, r_oe_n, r_we_n, r_ub_n, r_lb_n;
    logic [15:0] r_dq;
    logic        r_dq_oe;
    logic        r_ack;
    logic        r_blank1;
    logic        r_odd1;
    logic [23:0] r_rgb;

    logic [9:0]  w_next;
    logic        w_ls;
    logic        w_ls_fetch;
    logic        w_start;
    logic [9:0]  w_line;
    logic [19:0] w_start_addr;
    logic        w_blank0;
    logic [9:0]  w_wordx;
    logic [AW-1:0] w_raddr;
    logic [AW-1:0] w_waddr;
    logic [15:0] w_rdata;
    logic [7:0]  w_byte;
    logic [23:0] w_rgb;

    // r_primed keeps the first cycle after reset from looking like a line start.
    assign w_next = (vga_drawy == 10'(V_TOTAL - 1)) ? '0 : vga_drawy + 10'd1;
    assign w_ls = r_primed && (vga_drawy != r_drawy_q);
    assign w_ls_fetch = w_ls && (w_next < 10'(V_RES));
    assign w_line = w_ls_fetch ? w_next : r_pend_line;
    assign w_start_addr = (r_fb_active ? FB1_BASE : FB0_BASE)
                        + 20'(w_line) * 20'(WPL);
    assign w_start = ((r_state == ST_IDLE) && (w_ls_fetch || r_pend))
                  || (((r_state == ST_FETCH) || (r_state == ST_DRAIN)) && w_ls_fetch);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_drawy_q   <= '0;
            r_primed    <= 1'b0;
            r_fb_active <= 1'b0;
        end else begin
            r_drawy_q <= vga_drawy;
            r_primed  <= 1'b1;
            if (w_ls && (vga_drawy == 10'(V_RES)))
                r_fb_active <= fb_sel;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state     <= ST_IDLE;
            r_pend      <= 1'b0;
            r_pend_line <= '0;
            r_cnt       <= '0;
            r_half      <= 1'b0;
            r_cap_v     <= 1'b0;
            r_cap_half  <= 1'b0;
            r_cap_idx   <= '0;
            r_addr      <= '0;
            r_ce_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_ub_n      <= 1'b1;
            r_lb_n      <= 1'b1;
            r_dq        <= '0;
            r_dq_oe     <= 1'b0;
            r_ack       <= 1'b0;
        end else begin
            r_cap_v    <= (r_state == ST_FETCH);
            r_cap_half <= r_half;
            r_cap_idx  <= r_cnt;
            r_ack      <= 1'b0;
            if (w_ls_fetch && ((r_state == ST_WR1) || (r_state == ST_WR2))) begin
                r_pend      <= 1'b1;
                r_pend_line <= w_next;
            end
            if (w_start) begin
                r_state <= ST_FETCH;
                r_pend  <= 1'b0;
                r_cnt   <= '0;
                r_half  <= w_line[0];
                r_addr  <= w_start_addr;
                r_ce_n  <= 1'b0;
                r_oe_n  <= 1'b0;
                r_we_n  <= 1'b1;
                r_ub_n  <= 1'b0;
                r_lb_n  <= 1'b0;
                r_dq_oe <= 1'b0;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (bus.cpu_req) begin
                            r_state <= ST_WR1;
                            r_addr  <= bus.cpu_addr;
                            r_dq    <= bus.cpu_wdata;
                            r_ce_n  <= 1'b0;
                            r_we_n  <= 1'b0;
                            r_ub_n  <= ~bus.cpu_be[1];
                            r_lb_n  <= ~bus.cpu_be[0];
                            r_dq_oe <= 1'b1;
                        end
                    end
                    ST_FETCH: begin
                        if (r_cnt == AW'(WPL - 1)) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_cnt  <= r_cnt + 1'b1;
                            r_addr <= r_addr + 20'd1;
                        end
                    end
                    ST_DRAIN: begin
                        r_state <= ST_IDLE;
                        r_ce_n  <= 1'b1;
                        r_oe_n  <= 1'b1;
                        r_ub_n  <= 1'b1;
                        r_lb_n  <= 1'b1;
                    end
                    ST_WR1: begin
                        r_state <= ST_WR2;
                        r_we_n  <= 1'b1;
                        r_ack   <= 1'b1;
                    end
                    ST_WR2: begin
                        r_state <= ST_IDLE;
                        r_ce_n  <= 1'b1;
                        r_ub_n  <= 1'b1;
                        r_lb_n  <= 1'b1;
                        r_dq_oe <= 1'b0;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // Word on dq_i belongs to the address issued one cycle earlier.
    assign w_waddr = (r_cap_half ? AW'(WPL) : AW'(0)) + r_cap_idx;
    assign w_blank0 = (vga_drawx >= 10'(H_RES)) || (vga_drawy >= 10'(V_RES));
    assign w_wordx = (BPP == 16) ? vga_drawx : {1'b0, vga_drawx[9:1]};
    assign w_raddr = w_blank0 ? AW'(0)
                   : (vga_drawy[0] ? AW'(WPL) : AW'(0)) + AW'(w_wordx);

    line_buffer #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_lbuf (
        .clk     (clk_clk),
        .i_we    (r_cap_v),
        .i_waddr (w_waddr),
        .i_wdata (bus.sram_dq_i),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    assign w_byte = r_odd1 ? w_rdata[15:8] : w_rdata[7:0];
    assign w_rgb = (BPP == 16) ? expand565(w_rdata) : expand332(w_byte);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_blank1 <= 1'b1;
            r_odd1   <= 1'b0;
            r_rgb    <= '0;
        end else begin
            r_blank1 <= w_blank0;
            r_odd1   <= vga_drawx[0];
            r_rgb    <= r_blank1 ? '0 : w_rgb;
        end
    end

    assign fb_active      = r_fb_active;
    assign vga_r          = r_rgb[23:16];
    assign vga_g          = r_rgb[15:8];
    assign vga_b          = r_rgb[7:0];
    assign bus.cpu_ack    = r_ack;
    assign bus.sram_addr  = r_addr;
    assign bus.sram_ce_n  = r_ce_n;
    assign bus.sram_oe_n  = r_oe_n;
    assign bus.sram_we_n  = r_we_n;
    assign bus.sram_ub_n  = r_ub_n;
    assign bus.sram_lb_n  = r_lb_n;
    assign bus.sram_dq_o  = r_dq;
    assign bus.sram_dq_oe = r_dq_oe;

endmodule

// File: tb/tb_sram_scanline_fetcher.sv
// Directed bench for sram_scanline_fetcher: one RGB565 and one RGB332
// instance at a reduced 16x8 resolution sharing the same scan position.
module tb_sram_scanline_fetcher;
    import ece385_vga_pkg::*;

    localparam int WPL16 = 16;

    logic       clk;
    logic       rst_n;
    logic [9:0] drawx;
    logic [9:0] drawy;
    logic       fb_sel;
    logic       fa16, fa8;
    logic [7:0] r16, g16, bl16;
    logic [7:0] r8, g8, bl8;

    int total = 0;
    int bad = 0;

    logic [15:0] mem [logic [19:0]];

    sram_scanline_fetcher_if b16 ();
    sram_scanline_fetcher_if b8 ();

    sram_scanline_fetcher #(
        .H_RES(16), .V_RES(8), .V_TOTAL(12), .BPP(16),
        .FB0_BASE(20'h00000), .FB1_BASE(20'h40000)
    ) u16 (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .vga_drawx(drawx), .vga_drawy(drawy),
        .fb_sel(fb_sel), .fb_active(fa16),
        .vga_r(r16), .vga_g(g16), .vga_b(bl16),
        .bus(b16)
    );

    sram_scanline_fetcher #(
        .H_RES(16), .V_RES(8), .V_TOTAL(12), .BPP(8),
        .FB0_BASE(20'h00000), .FB1_BASE(20'h40000)
    ) u8 (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .vga_drawx(drawx), .vga_drawy(drawy),
        .fb_sel(fb_sel), .fb_active(fa8),
        .vga_r(r8), .vga_g(g8), .vga_b(bl8),
        .bus(b8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] rd(input logic [19:0] a);
        return mem.exists(a) ? mem[a] : 16'h0000;
    endfunction

    // SRAM model: data appears one cycle after its address.
    always @(posedge clk) begin
        b16.sram_dq_i <= rd(b16.sram_addr);
        b8.sram_dq_i  <= rd(b8.sram_addr);
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_16"},
            {r16, g16, bl16, fa16, b16.cpu_ack, b16.sram_ce_n, b16.sram_oe_n,
             b16.sram_we_n, b16.sram_ub_n, b16.sram_lb_n, b16.sram_dq_oe,
             b16.sram_addr},
            {24'h0, 1'b0, 1'b0, 5'h1F, 1'b0, 20'h0});
        chk({nm, "_8"},
            {r8, g8, bl8, fa8, b8.cpu_ack, b8.sram_ce_n, b8.sram_oe_n,
             b8.sram_we_n, b8.sram_ub_n, b8.sram_lb_n, b8.sram_dq_oe,
             b8.sram_addr},
            {24'h0, 1'b0, 1'b0, 5'h1F, 1'b0, 20'h0});
    endtask

    task automatic set_y(input logic [9:0] y, output logic [19:0] a16,
                         output logic [19:0] a8, output logic o16);
        @(negedge clk);
        drawy = y;
        @(negedge clk);
        a16 = b16.sram_addr;
        a8  = b8.sram_addr;
        o16 = b16.sram_oe_n;
        repeat (22) @(negedge clk);
    endtask

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [23:0] e16;
        logic [23:0] e8;
    } vec_t;

    vec_t vec [11];

    logic [19:0] a16, a8;
    logic        o16;
    int          ack_cnt, ack_k, we_cnt, we_k, oe_cnt;
    logic [39:0] we_snap;

    initial begin
        rst_n = 1'b0;
        drawx = '0;
        drawy = 10'd10;
        fb_sel = 1'b0;
        b16.cpu_req = 1'b0; b16.cpu_addr = '0; b16.cpu_wdata = '0; b16.cpu_be = '0;
        b8.cpu_req = 1'b0;  b8.cpu_addr = '0;  b8.cpu_wdata = '0;  b8.cpu_be = '0;
        mem[20'd0]  = 16'h1CE0;
        mem[20'd1]  = 16'h0003;
        mem[20'd15] = 16'hFFE0;
        mem[20'd21] = 16'hF800;
        mem[20'd22] = 16'h07E0;
        mem[20'd31] = 16'h001F;

        vec[0]  = '{10'd0,   10'd0, 24'h189E00, 24'hFF0000};
        vec[1]  = '{10'd1,   10'd0, 24'h000018, 24'h00FF00};
        vec[2]  = '{10'd2,   10'd0, 24'h000000, 24'h0000FF};
        vec[3]  = '{10'd15,  10'd0, 24'hFFFF00, 24'h000000};
        vec[4]  = '{10'd16,  10'd0, 24'h000000, 24'h000000};
        vec[5]  = '{10'd5,   10'd1, 24'hFF0000, 24'h000000};
        vec[6]  = '{10'd6,   10'd1, 24'h00FF00, 24'h000000};
        vec[7]  = '{10'd14,  10'd1, 24'h000000, 24'hFF0000};
        vec[8]  = '{10'd15,  10'd1, 24'h0000FF, 24'hFFFFFF};
        vec[9]  = '{10'd700, 10'd1, 24'h000000, 24'h000000};
        vec[10] = '{10'd5,   10'd8, 24'h000000, 24'h000000};

        repeat (3) @(negedge clk);
        chk_reset("reset");

        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_after_rst", {b16.sram_oe_n, b8.sram_oe_n}, 2'b11);

        set_y(10'd11, a16, a8, o16);
        chk("fetch_l0_addr", {o16, a16, a8}, {1'b0, 20'd0, 20'd0});
        set_y(10'd0, a16, a8, o16);
        chk("fetch_l1_addr", {o16, a16, a8}, {1'b0, 20'd16, 20'd8});

        for (int i = 0; i < 11; i++) begin
            if (vec[i].y != drawy)
                set_y(vec[i].y, a16, a8, o16);
            @(negedge clk);
            drawx = vec[i].x;
            repeat (2) @(posedge clk);
            @(negedge clk);
            chk($sformatf("pix16_%0d", i), {r16, g16, bl16}, vec[i].e16);
            chk($sformatf("pix8_%0d", i), {r8, g8, bl8}, vec[i].e8);
        end

        set_y(10'd1, a16, a8, o16);
        drawx = 10'd16;
        repeat (3) @(negedge clk);
        drawx = 10'd5;
        @(negedge clk);
        chk("latency_1clk", r16, 8'h00);
        @(negedge clk);
        chk("latency_2clk", r16, 8'hFF);

        ack_cnt = 0; ack_k = 0; we_cnt = 0; we_k = 0; we_snap = '0;
        drawy = 10'd2;
        for (int k = 1; k <= WPL16 + 8; k++) begin
            @(negedge clk);
            if (k == 1)
                chk("fetch_l3_addr", {b16.sram_oe_n, b16.sram_addr}, {1'b0, 20'd48});
            if (b16.sram_we_n == 1'b0) begin
                we_cnt++;
                we_k = k;
                we_snap = {b16.sram_addr, b16.sram_dq_o, b16.sram_ub_n,
                           b16.sram_lb_n, b16.sram_dq_oe, b16.sram_ce_n};
            end
            if (b16.cpu_ack) begin
                if (ack_cnt == 0) ack_k = k;
                ack_cnt++;
                b16.cpu_req = 1'b0;
            end
            if (k == 10) begin
                b16.cpu_addr  = 20'h12345;
                b16.cpu_wdata = 16'hBEEF;
                b16.cpu_be    = 2'b10;
                b16.cpu_req   = 1'b1;
            end
        end
        chk("ack_count", ack_cnt, 1);
        chk("ack_cycle", ack_k, WPL16 + 4);
        chk("we_count", we_cnt, 1);
        chk("we_cycle", we_k, WPL16 + 3);
        chk("we_bus", we_snap, {20'h12345, 16'hBEEF, 1'b0, 1'b1, 1'b1, 1'b0});

        repeat (4) @(negedge clk);
        drawy = 10'd3;
        repeat (3) @(negedge clk);
        chk("fetch_active", b16.sram_oe_n, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_oe", b16.sram_oe_n, 1'b1);
        chk("rst_state", u16.r_state, ST_IDLE);
        chk_reset("reset_mid");
        @(negedge clk);
        rst_n = 1'b1;
        oe_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (b16.sram_oe_n == 1'b0 || b8.sram_oe_n == 1'b0) oe_cnt++;
        end
        chk("no_read_after_rst", oe_cnt, 0);
        set_y(10'd4, a16, a8, o16);
        chk("fetch_l5_addr", {o16, a16}, {1'b0, 20'd80});

        set_y(10'd5, a16, a8, o16);
        fb_sel = 1'b1;
        set_y(10'd6, a16, a8, o16);
        chk("flip_l7_fb0", {o16, a16, a8}, {1'b0, 20'd112, 20'd56});
        set_y(10'd7, a16, a8, o16);
        chk("flip_wait", {fa16, fa8}, 2'b00);
        set_y(10'd8, a16, a8, o16);
        chk("flip_at_vres", {fa16, fa8}, 2'b11);
        set_y(10'd9, a16, a8, o16);
        set_y(10'd10, a16, a8, o16);
        set_y(10'd11, a16, a8, o16);
        chk("flip_l0_fb1", {o16, a16, a8}, {1'b0, 20'h40000, 20'h40000});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
